lif_ring_network: RTL and testbench
===================================

Name: lif_ring_network

Overview:
- Parametrised ring of N leaky integrate-and-fire neurons with programmable per-neuron synaptic weights and an external drive into neuron 0.
- Successor to the fixed two-neuron/two-synapse pair. Adds real membrane integration, leak, threshold, refractory period, open-chain/closed-ring mode and a spike counter.
- Sits under the top level. The top level maps `spike_out` and `spike_count` onto `uo_out`/`uio_out`.

Parameters:
- N_NEURONS, 4, number of neurons in the ring (2..8).
- V_WIDTH, 8, membrane potential width (unsigned).
- THRESHOLD, 64, firing threshold. Constraint: 1..2^V_WIDTH-1.
- LEAK_SHIFT, 3, leak is v>>LEAK_SHIFT per enabled cycle.
- REFRACT, 2, refractory cycles after a spike (0..15).
- W_RESET, 64, reset value of every weight register.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- enable  in  1  network advances only when high
- mode  in  1  0 = open chain (neuron 0 fed by drive only), 1 = closed ring (neuron N-1 also feeds neuron 0)
- drive  in  V_WIDTH  external input current added to neuron 0 each enabled cycle
- weight_we  in  1  weight write strobe
- weight_idx  in  3  target neuron of the weight write
- weight_data  in  V_WIDTH  weight value
- spike_out  out  N_NEURONS  registered one-cycle spike per neuron
- spike_any  out  1  registered OR of the next-state spikes (same cycle as `spike_out`)
- spike_count  out  8  saturating count of neuron N-1 spikes

Behaviour:

Reset (sync, has priority over all other inputs):
- All v[i]=0, rc[i]=0, spike_out=0, spike_any=0, spike_count=0, weight[i]=W_RESET.
- Reset mid-oscillation clears everything at the next edge; no spike is emitted on the reset cycle.

Input current per neuron i (from registered previous-cycle spikes):
- in[i] = (spike_out[pred(i)] ? weight[i] : 0) + (i==0 ? drive : 0).
- pred(i)=i-1 for i>0.
- pred(0)=N-1 when mode=1; neuron 0 has no synaptic input when mode=0.
- The spike-to-successor latency is therefore exactly 1 cycle per hop.

Update per neuron when enable=1:
- If rc[i]>0: v[i]<=0, rc[i]<=rc[i]-1, spike_out[i]<=0. Input current is discarded.
- Else compute vn = v - (v>>LEAK_SHIFT) + in[i], at width V_WIDTH+2, saturated to 2^V_WIDTH-1.
  - If vn>=THRESHOLD: spike_out[i]<=1, v[i]<=0, rc[i]<=REFRACT.
  - Else: v[i]<=vn, spike_out[i]<=0.
- Simultaneous drive and synaptic spike into neuron 0 sum before saturation.

When enable=0:
- v, rc, weights and spike_count hold.
- spike_out<=0 and spike_any<=0. In-flight spikes are dropped; no spike is lost on re-enable beyond that.

Weight writes:
- weight_we=1 with weight_idx<N_NEURONS writes weight[weight_idx]<=weight_data at the edge. The write is independent of `enable`.
- weight_idx>=N_NEURONS is ignored.
- The new value is used from the next cycle. A write on the same cycle a spike is consumed uses the old value.

spike_count:
- Increments on each cycle the registered spike_out[N-1] is 1, saturating at 255 (never wraps).
- Cleared only by reset.

Test Plan (defaults, mode as stated):
1. Chain integration: reset, mode=0, enable=1, drive=16 constant.
   - v0 follows 16, 30, 43, 54 and spike_out[0]=1 on the 5th enabled cycle.
   - spike_out[1], [2], [3] follow on cycles 6, 7, 8.
   - Neuron 0 re-fires every 7 cycles (1 spike + 2 refractory + 4 integrate).
2. Ring oscillation: reset, mode=1, drive=64 for one cycle then 0.
   - Spikes circulate 0→1→2→3→0 with period 4 indefinitely.
   - spike_count reaches 10 after 10 laps.
   - spike_any is high every cycle once running.
3. Weight kill: during scenario 2, write weight_idx=1, weight_data=32.
   - Neuron 1 receives 32 and does not fire; v1 decays 32→28→25→...
   - No further spikes anywhere after the current lap.
   - Write with weight_idx=5 has no effect.
4. Saturation: weight[0]=255, mode=1, drive=255 when neuron 3 spike arrives.
   - vn clamps to 255, neuron 0 spikes, v0=0 next cycle, no wrap to a small value.
5. Enable/refractory: deassert enable for 5 cycles mid-ring.
   - spike_out=0, v/rc/spike_count frozen.
   - After re-enable, refractory counts resume from held values.
6. Reset and counter:
   - Run the ring for 300 laps: spike_count holds at 255.
   - Assert reset for one cycle mid-lap: all outputs 0 and weights =64 at the next edge, no spikes until re-stimulated.

Source files
------------

// File: rtl/lif_ring_network.sv
// ---------------------------------------------------------------------------
// lif_ring_network
// Ring (or open chain) of N leaky integrate-and-fire neurons. Each neuron
// integrates a weighted copy of its predecessor's registered spike; neuron 0
// additionally integrates an external drive current. A spike forces the
// neuron into a refractory period. Neuron N-1 spikes are counted (saturating).
//
// Ports
//   clk          clock
//   reset        synchronous active-high reset, priority over everything
//   enable       network advances only when high
//   mode         0 = open chain, 1 = closed ring (N-1 feeds neuron 0)
//   drive        external current into neuron 0 per enabled cycle
//   weight_we    weight write strobe (independent of enable)
//   weight_idx   target neuron of the weight write (>= N_NEURONS ignored)
//   weight_data  weight value
//   spike_out    registered one-cycle spike per neuron
//   spike_any    registered OR of spike_out
//   spike_count  saturating count of neuron N-1 spikes
// ---------------------------------------------------------------------------
module lif_ring_network #(
   parameter int unsigned N_NEURONS  = 4,
   parameter int unsigned V_WIDTH    = 8,
   parameter int unsigned THRESHOLD  = 64,
   parameter int unsigned LEAK_SHIFT = 3,
   parameter int unsigned REFRACT    = 2,
   parameter int unsigned W_RESET    = 64
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 enable,
   input  logic                 mode,
   input  logic [V_WIDTH-1:0]   drive,
   input  logic                 weight_we,
   input  logic [2:0]           weight_idx,
   input  logic [V_WIDTH-1:0]   weight_data,
   output logic [N_NEURONS-1:0] spike_out,
   output logic                 spike_any,
   output logic [7:0]           spike_count
);

   // Sum width leaves headroom for v + weight + drive before clamping.
   localparam int unsigned SUM_W = V_WIDTH + 2;
   localparam int unsigned RC_W  = 4;
   localparam int unsigned CNT_W = 8;

   localparam logic [SUM_W-1:0]   V_MAX   = SUM_W'((2 ** V_WIDTH) - 1);
   localparam logic [SUM_W-1:0]   V_THR   = SUM_W'(THRESHOLD);
   localparam logic [RC_W-1:0]    RC_LOAD = RC_W'(REFRACT);
   localparam logic [V_WIDTH-1:0] W_INIT  = V_WIDTH'(W_RESET);
   localparam logic [CNT_W-1:0]   CNT_MAX = '1;

   // Per-neuron state
   logic [V_WIDTH-1:0] v_q  [N_NEURONS];
   logic [V_WIDTH-1:0] v_d  [N_NEURONS];
   logic [RC_W-1:0]    rc_q [N_NEURONS];
   logic [RC_W-1:0]    rc_d [N_NEURONS];
   logic [V_WIDTH-1:0] w_q  [N_NEURONS];
   logic [V_WIDTH-1:0] w_d  [N_NEURONS];

   // Datapath intermediates
   logic [SUM_W-1:0]     in_cur [N_NEURONS];
   logic [SUM_W-1:0]     v_sum  [N_NEURONS];
   logic [SUM_W-1:0]     v_cand [N_NEURONS];
   logic [N_NEURONS-1:0] pred_spike;
   logic [N_NEURONS-1:0] spike_d;
   logic [CNT_W-1:0]     count_d;

   // Predecessor spike per neuron; neuron 0 only hears N-1 in ring mode.
   assign pred_spike = {spike_out[N_NEURONS-2:0], spike_out[N_NEURONS-1] & mode};

   // Synaptic input current, plus external drive on neuron 0.
   always_comb begin
      for (int i = 0; i < N_NEURONS; i++) begin
         in_cur[i] = pred_spike[i] ? SUM_W'(w_q[i]) : '0;
      end
      in_cur[0] = in_cur[0] + SUM_W'(drive);
   end

   // Leak, integrate and clamp to the membrane range.
   always_comb begin
      for (int i = 0; i < N_NEURONS; i++) begin
         v_sum[i]  = SUM_W'(v_q[i]) - SUM_W'(v_q[i] >> LEAK_SHIFT) + in_cur[i];
         v_cand[i] = (v_sum[i] > V_MAX) ? V_MAX : v_sum[i];
      end
   end

   // Neuron next state: refractory countdown, fire, or integrate.
   always_comb begin
      for (int i = 0; i < N_NEURONS; i++) begin
         v_d[i]  = v_q[i];
         rc_d[i] = rc_q[i];
      end
      spike_d = '0;

      if (enable) begin
         for (int i = 0; i < N_NEURONS; i++) begin
            if (rc_q[i] != '0) begin
               // Input arriving during refractory is discarded.
               v_d[i]  = '0;
               rc_d[i] = rc_q[i] - RC_W'(1);
            end else if (v_cand[i] >= V_THR) begin
               spike_d[i] = 1'b1;
               v_d[i]     = '0;
               rc_d[i]    = RC_LOAD;
            end else begin
               v_d[i] = V_WIDTH'(v_cand[i]);
            end
         end
      end
   end

   // Weight write port; out-of-range indices match no neuron.
   always_comb begin
      for (int i = 0; i < N_NEURONS; i++) begin
         w_d[i] = w_q[i];
         if (weight_we && (int'(weight_idx) == i)) begin
            w_d[i] = weight_data;
         end
      end
   end

   // Saturating counter of neuron N-1 spikes, frozen while disabled.
   always_comb begin
      count_d = spike_count;
      if (enable && spike_out[N_NEURONS-1] && (spike_count != CNT_MAX)) begin
         count_d = spike_count + CNT_W'(1);
      end
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < N_NEURONS; i++) begin
            v_q[i]  <= '0;
            rc_q[i] <= '0;
            w_q[i]  <= W_INIT;
         end
         spike_out   <= '0;
         spike_any   <= 1'b0;
         spike_count <= '0;
      end else begin
         for (int i = 0; i < N_NEURONS; i++) begin
            v_q[i]  <= v_d[i];
            rc_q[i] <= rc_d[i];
            w_q[i]  <= w_d[i];
         end
         spike_out   <= spike_d;
         spike_any   <= |spike_d;
         spike_count <= count_d;
      end
   end

endmodule

// File: tb/tb_lif_ring_network.sv
// ---------------------------------------------------------------------------
// tb_lif_ring_network
// Self-checking bench: a directed table for chain integration, hand-written
// sequences for ring, weight, saturation, enable/refractory and reset corner
// cases, then randomized stimulus against a behavioural neuron model.
// ---------------------------------------------------------------------------
module tb_lif_ring_network;

   localparam int N    = 4;
   localparam int VW   = 8;
   localparam int THR  = 64;
   localparam int LS   = 3;
   localparam int RF   = 2;
   localparam int WR   = 64;
   localparam int VMAX = 255;

   logic          clk;
   logic          reset;
   logic          enable;
   logic          mode;
   logic [VW-1:0] drive;
   logic          weight_we;
   logic [2:0]    weight_idx;
   logic [VW-1:0] weight_data;
   logic [N-1:0]  spike_out;
   logic          spike_any;
   logic [7:0]    spike_count;

   lif_ring_network #(
      .N_NEURONS  (N),
      .V_WIDTH    (VW),
      .THRESHOLD  (THR),
      .LEAK_SHIFT (LS),
      .REFRACT    (RF),
      .W_RESET    (WR)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .enable      (enable),
      .mode        (mode),
      .drive       (drive),
      .weight_we   (weight_we),
      .weight_idx  (weight_idx),
      .weight_data (weight_data),
      .spike_out   (spike_out),
      .spike_any   (spike_any),
      .spike_count (spike_count)
   );

   always #5 clk = ~clk;

   int nvec  = 0;
   int nfail = 0;
   int cyc   = 0;

   // Behavioural model state
   int mv  [N];
   int mrc [N];
   int mw  [N];
   bit mspk[N];
   int mcnt;

   typedef struct {
      bit en;
      bit md;
      int drv;
      int exp_spk;
      int exp_cnt;
   } vec_t;

   vec_t tbl[18];

   task automatic check(input string name, input logic [31:0] got, input int exp);
      nvec++;
      if (got !== 32'(exp)) begin
         nfail++;
         $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, got, exp);
      end
   endtask

   function automatic int model_vec();
      int r = 0;
      for (int i = 0; i < N; i++) if (mspk[i]) r = r | (1 << i);
      return r;
   endfunction

   // One clock of the network, straight from the neuron rules.
   task automatic model_update(input bit rst, input bit en, input bit md, input int drv,
                               input bit we, input int idx, input int wd);
      int nv[N];
      int nrc[N];
      bit nspk[N];
      if (rst) begin
         for (int i = 0; i < N; i++) begin
            mv[i] = 0; mrc[i] = 0; mw[i] = WR; mspk[i] = 0;
         end
         mcnt = 0;
         return;
      end
      if (en) begin
         for (int i = 0; i < N; i++) begin
            int p;
            int cur;
            int vn;
            bit syn;
            p   = (i + N - 1) % N;
            syn = mspk[p] && ((i != 0) || md);
            cur = (syn ? mw[i] : 0) + ((i == 0) ? drv : 0);
            nspk[i] = 0;
            if (mrc[i] > 0) begin
               nv[i]  = 0;
               nrc[i] = mrc[i] - 1;
            end else begin
               vn = mv[i] - mv[i] / (1 << LS) + cur;
               if (vn > VMAX) vn = VMAX;
               if (vn >= THR) begin
                  nspk[i] = 1; nv[i] = 0; nrc[i] = RF;
               end else begin
                  nv[i] = vn; nrc[i] = 0;
               end
            end
         end
         if (mspk[N-1] && mcnt < 255) mcnt++;
         for (int i = 0; i < N; i++) begin
            mv[i] = nv[i]; mrc[i] = nrc[i]; mspk[i] = nspk[i];
         end
      end else begin
         for (int i = 0; i < N; i++) mspk[i] = 0;
      end
      if (we && idx < N) mw[idx] = wd;
   endtask

   task automatic step(input bit rst, input bit en, input bit md, input int drv,
                       input bit we, input int idx, input int wd, input bit chk);
      reset       = rst;
      enable      = en;
      mode        = md;
      drive       = VW'(drv);
      weight_we   = we;
      weight_idx  = 3'(idx);
      weight_data = VW'(wd);
      @(posedge clk);
      model_update(rst, en, md, drv, we, idx, wd);
      #1;
      cyc++;
      if (chk) begin
         check("spike_out", 32'(spike_out), model_vec());
         check("spike_any", 32'(spike_any), (model_vec() != 0) ? 1 : 0);
         check("spike_count", 32'(spike_count), mcnt);
      end
   endtask

   task automatic run(input int n, input bit en, input bit md, input int drv);
      repeat (n) step(0, en, md, drv, 0, 0, 0, 1);
   endtask

   initial begin
      int spk_seq[18];
      int cnt_seq[18];
      bit md_r;
      clk = 0; reset = 1; enable = 0; mode = 0; drive = '0;
      weight_we = 0; weight_idx = '0; weight_data = '0;

      // Reset state
      step(1, 0, 0, 0, 0, 0, 0, 1);
      step(1, 1, 1, 200, 0, 0, 0, 1);
      check("rst_spike_out", 32'(spike_out), 0);
      check("rst_spike_count", 32'(spike_count), 0);

      // Chain integration table: drive 16, open chain
      spk_seq = '{0,0,0,0,1,2,4,8,0,0,0,1,2,4,8,0,0,0};
      cnt_seq = '{0,0,0,0,0,0,0,0,1,1,1,1,1,1,1,2,2,2};
      for (int r = 0; r < 18; r++) begin
         tbl[r].en      = (r != 16);
         tbl[r].md      = 0;
         tbl[r].drv     = 16;
         tbl[r].exp_spk = spk_seq[r];
         tbl[r].exp_cnt = cnt_seq[r];
      end
      step(1, 0, 0, 0, 0, 0, 0, 1);
      for (int r = 0; r < 18; r++) begin
         step(0, tbl[r].en, tbl[r].md, tbl[r].drv, 0, 0, 0, 0);
         check("tbl_spike_out", 32'(spike_out), tbl[r].exp_spk);
         check("tbl_spike_any", 32'(spike_any), (tbl[r].exp_spk != 0) ? 1 : 0);
         check("tbl_spike_count", 32'(spike_count), tbl[r].exp_cnt);
      end

      // Ring oscillation, with an out-of-range weight write mid-run
      step(1, 0, 0, 0, 0, 0, 0, 1);
      step(0, 1, 1, 64, 0, 0, 0, 1);
      run(19, 1, 1, 0);
      step(0, 1, 1, 0, 1, 5, 0, 1);
      run(20, 1, 1, 0);
      check("ring_count_10", 32'(spike_count), 10);
      check("ring_any_high", 32'(spike_any), 1);

      // Weight kill on neuron 1; same-cycle consumption still uses old weight
      step(0, 1, 1, 0, 1, 1, 32, 1);
      check("kill_old_weight", 32'(spike_out), 2);
      run(16, 1, 1, 0);
      check("kill_silent", 32'(spike_out), 0);
      check("kill_count", 32'(spike_count), 11);

      // Saturation: weight 255 plus drive into neuron 0
      step(1, 0, 0, 0, 0, 0, 0, 1);
      step(0, 1, 1, 64, 1, 0, 255, 1);
      run(3, 1, 1, 0);
      step(0, 1, 1, 255, 0, 0, 0, 1);
      check("sat_255_fire", 32'(spike_out), 1);
      run(3, 1, 1, 0);
      step(0, 1, 1, 1, 0, 0, 0, 1);
      check("sat_256_fire", 32'(spike_out), 1);
      run(4, 1, 1, 0);

      // Enable freeze with refractory resume on neuron 0
      step(1, 0, 0, 0, 0, 0, 0, 1);
      step(0, 1, 1, 64, 0, 0, 0, 1);
      run(4, 1, 1, 0);
      check("en_pre_spike0", 32'(spike_out), 1);
      for (int k = 0; k < 5; k++) begin
         step(0, 0, 1, 64, 0, 0, 0, 1);
         check("en_off_spikes", 32'(spike_out), 0);
         check("en_off_count", 32'(spike_count), 1);
      end
      step(0, 1, 1, 64, 0, 0, 0, 1);
      check("en_refr_1", 32'(spike_out), 0);
      step(0, 1, 1, 64, 0, 0, 0, 1);
      check("en_refr_2", 32'(spike_out), 0);
      step(0, 1, 1, 64, 0, 0, 0, 1);
      check("en_refr_done", 32'(spike_out), 1);
      run(6, 1, 1, 0);

      // Counter saturation, then reset mid-lap
      step(1, 0, 0, 0, 0, 0, 0, 1);
      step(0, 1, 1, 64, 0, 0, 0, 1);
      run(1199, 1, 1, 0);
      check("count_sat", 32'(spike_count), 255);
      step(0, 1, 1, 0, 1, 1, 32, 1);
      step(1, 1, 1, 0, 0, 0, 0, 1);
      check("mid_rst_spike_out", 32'(spike_out), 0);
      check("mid_rst_spike_any", 32'(spike_any), 0);
      check("mid_rst_count", 32'(spike_count), 0);
      run(5, 1, 1, 0);
      check("post_rst_quiet", 32'(spike_out), 0);
      step(0, 1, 1, 64, 0, 0, 0, 1);
      run(8, 1, 1, 0);
      check("post_rst_weights", 32'(spike_count), 2);

      // Randomized run against the model
      step(1, 0, 0, 0, 0, 0, 0, 1);
      md_r = 1;
      for (int k = 0; k < 2500; k++) begin
         bit rst;
         bit en;
         bit we;
         int sel;
         int drv;
         rst = ($urandom_range(0, 199) == 0);
         en  = ($urandom_range(0, 9) != 0);
         if ($urandom_range(0, 49) == 0) md_r = ~md_r;
         sel = int'($urandom_range(0, 9));
         if (sel < 5)       drv = 0;
         else if (sel < 8)  drv = int'($urandom_range(0, 30));
         else if (sel == 8) drv = 64;
         else               drv = 255;
         we = ($urandom_range(0, 19) == 0);
         step(rst, en, md_r, drv, we, int'($urandom_range(0, 7)),
              int'($urandom_range(0, 255)), 1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

endmodule
